// File: rtl/cpu_pkg.sv
// Types and default widths shared by the cpu pipeline and its memory arbiter.
package cpu_pkg;

   localparam int unsigned CPU_DW = 16;
   localparam int unsigned CPU_AW = 8;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic {OWN_IF, OWN_DM} owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave = arbiter, master = core/memory side.
interface mem_arbiter_if import cpu_pkg::*; #(
   parameter int unsigned DW = CPU_DW,
   parameter int unsigned AW = CPU_AW
) ();

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ack;
   logic          mem_cs;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          stall;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_ack, dm_rdata, dm_ack, mem_cs, mem_we, mem_addr, mem_wdata, stall
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_ack, dm_rdata, dm_ack, mem_cs, mem_we, mem_addr, mem_wdata, stall
   );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Owner selection: lone requester wins; under contention data wins unless it had the last grant.
module arb_pick import cpu_pkg::*; (
   input  logic   if_req,
   input  logic   dm_req,
   input  logic   last_dm,
   output owner_t owner
);

   always_comb begin
      owner = OWN_IF;
      if (dm_req && (!if_req || !last_dm)) begin
         owner = OWN_DM;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory with
// WAIT extra cycles per access and a combinational pipeline stall.
module mem_arbiter import cpu_pkg::*; #(
   parameter int unsigned DW   = CPU_DW,
   parameter int unsigned AW   = CPU_AW,
   parameter int unsigned WAIT = 1
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   state_t        state;
   state_t        state_next;
   owner_t        owner;
   owner_t        pick;
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic [3:0]    cnt;
   logic          last_dm;
   logic [DW-1:0] if_rdata_q;
   logic [DW-1:0] dm_rdata_q;
   logic          grant;
   logic          done;

   arb_pick u_pick (
      .if_req  (bus.if_req),
      .dm_req  (bus.dm_req),
      .last_dm (last_dm),
      .owner   (pick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      done       = 1'b0;
      bus.mem_cs = 1'b0;
      bus.mem_we = 1'b0;
      bus.if_ack = 1'b0;
      bus.dm_ack = 1'b0;
      case (state)
         IDLE: begin
            if (bus.if_req || bus.dm_req) begin
               grant      = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            bus.mem_cs = 1'b1;
            bus.mem_we = we_q;
            if (cnt == '0) begin
               done       = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            bus.if_ack = (owner == OWN_IF);
            bus.dm_ack = (owner == OWN_DM);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // we_q is only ever set for a data-owner write, so it drives mem_we directly
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner      <= OWN_IF;
         last_dm    <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         cnt        <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else if (grant) begin
         owner   <= pick;
         last_dm <= (pick == OWN_DM);
         addr_q  <= (pick == OWN_DM) ? bus.dm_addr : bus.if_addr;
         we_q    <= (pick == OWN_DM) && bus.dm_we;
         wdata_q <= bus.dm_wdata;
         cnt     <= 4'(WAIT);
      end else if (state == ACCESS) begin
         if (cnt != '0) begin
            cnt <= cnt - 4'd1;
         end
         if (done && !we_q) begin
            if (owner == OWN_IF) begin
               if_rdata_q <= bus.mem_rdata;
            end else begin
               dm_rdata_q <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.stall     = (bus.if_req & ~bus.if_ack) | (bus.dm_req & ~bus.dm_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with WAIT=1 and a combinational ROM on the memory side.
module tb_mem_arbiter;
   import cpu_pkg::*;

   logic        clk;
   logic        rst;
   logic [15:0] rom [256];
   int          checks = 0;
   int          errors = 0;
   logic        exp_dm;

   mem_arbiter_if #(.DW(16), .AW(8)) bus ();

   mem_arbiter #(.DW(16), .AW(8), .WAIT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.mem_rdata = rom[bus.mem_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // each cycle is observed 2 time units after its opening rising edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'(i);
      rom[8'h10] = 16'h1234;
      rom[8'h30] = 16'hCAFE;
      rom[8'h40] = 16'h5555;
      rom[8'h60] = 16'h0F0F;

      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      #1 rst = 1'b0;

      for (int c = 0; c < 4; c++) begin
         step();
         bus.if_req  = 1'($urandom_range(0, 1));
         bus.dm_req  = 1'($urandom_range(0, 1));
         bus.dm_we   = 1'($urandom_range(0, 1));
         bus.if_addr = 8'($urandom_range(0, 255));
         bus.dm_addr = 8'($urandom_range(0, 255));
         settle();
         chk("rst_mem_cs", bus.mem_cs, 0);
         chk("rst_mem_we", bus.mem_we, 0);
         chk("rst_if_ack", bus.if_ack, 0);
         chk("rst_dm_ack", bus.dm_ack, 0);
         chk("rst_if_rdata", bus.if_rdata, 0);
         chk("rst_dm_rdata", bus.dm_rdata, 0);
         chk("rst_stall", bus.stall, {31'b0, bus.if_req | bus.dm_req});
      end
      bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      rst = 1'b1;

      // data write
      step();
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 8'h20; bus.dm_wdata = 16'hBEEF;
      settle();
      chk("wr_c0_stall", bus.stall, 1);
      chk("wr_c0_cs", bus.mem_cs, 0);
      step();
      bus.dm_addr = 8'h21; bus.dm_wdata = 16'h0000;
      settle();
      chk("wr_c1_cs", bus.mem_cs, 1);
      chk("wr_c1_we", bus.mem_we, 1);
      chk("wr_c1_wdata", bus.mem_wdata, 16'hBEEF);
      chk("wr_c1_addr", bus.mem_addr, 8'h20);
      step();
      chk("wr_c2_we", bus.mem_we, 1);
      chk("wr_c2_wdata", bus.mem_wdata, 16'hBEEF);
      chk("wr_c2_ack", bus.dm_ack, 0);
      chk("wr_c2_stall", bus.stall, 1);
      step();
      chk("wr_c3_dm_ack", bus.dm_ack, 1);
      chk("wr_c3_if_ack", bus.if_ack, 0);
      chk("wr_c3_dm_rdata", bus.dm_rdata, 0);
      chk("wr_c3_stall", bus.stall, 0);
      chk("wr_c3_cs", bus.mem_cs, 0);
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;

      // single fetch
      step();
      chk("wr_c4_ack", bus.dm_ack, 0);
      bus.if_req = 1'b1; bus.if_addr = 8'h10;
      settle();
      chk("if_c0_stall", bus.stall, 1);
      step();
      chk("if_c1_cs", bus.mem_cs, 1);
      chk("if_c1_addr", bus.mem_addr, 8'h10);
      chk("if_c1_we", bus.mem_we, 0);
      chk("if_c1_stall", bus.stall, 1);
      step();
      chk("if_c2_cs", bus.mem_cs, 1);
      chk("if_c2_addr", bus.mem_addr, 8'h10);
      chk("if_c2_stall", bus.stall, 1);
      step();
      chk("if_c3_ack", bus.if_ack, 1);
      chk("if_c3_rdata", bus.if_rdata, 16'h1234);
      chk("if_c3_stall", bus.stall, 0);
      chk("if_c3_cs", bus.mem_cs, 0);
      bus.if_req = 1'b0;

      // simultaneous fetch and data read: data first
      step();
      bus.if_req = 1'b1; bus.if_addr = 8'h30;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 8'h40;
      settle();
      chk("both_c0_stall", bus.stall, 1);
      step();
      chk("both_c1_addr", bus.mem_addr, 8'h40);
      chk("both_c1_stall", bus.stall, 1);
      step();
      chk("both_c2_cs", bus.mem_cs, 1);
      chk("both_c2_if_rdata", bus.if_rdata, 16'h1234);
      step();
      chk("both_c3_dm_ack", bus.dm_ack, 1);
      chk("both_c3_if_ack", bus.if_ack, 0);
      chk("both_c3_dm_rdata", bus.dm_rdata, 16'h5555);
      chk("both_c3_stall", bus.stall, 1);
      bus.dm_req = 1'b0;
      step();
      chk("both_c4_cs", bus.mem_cs, 0);
      chk("both_c4_stall", bus.stall, 1);
      step();
      chk("both_c5_addr", bus.mem_addr, 8'h30);
      chk("both_c5_stall", bus.stall, 1);
      step();
      chk("both_c6_stall", bus.stall, 1);
      step();
      chk("both_c7_if_ack", bus.if_ack, 1);
      chk("both_c7_if_rdata", bus.if_rdata, 16'hCAFE);
      chk("both_c7_dm_rdata", bus.dm_rdata, 16'h5555);
      chk("both_c7_stall", bus.stall, 0);
      bus.if_req = 1'b0;

      // continuous contention: DM, IF, DM, IF
      step();
      bus.if_req = 1'b1; bus.if_addr = 8'h60;
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 8'h50; bus.dm_wdata = 16'h1111;
      for (int k = 0; k < 4; k++) begin
         exp_dm = (k % 2 == 0);
         settle();
         chk("cont_idle_cs", bus.mem_cs, 0);
         step();
         chk("cont_c1_cs", bus.mem_cs, 1);
         chk("cont_c1_we", bus.mem_we, {31'b0, exp_dm});
         chk("cont_c1_addr", bus.mem_addr, exp_dm ? 32'h50 : 32'h60);
         step();
         step();
         chk("cont_dm_ack", bus.dm_ack, {31'b0, exp_dm});
         chk("cont_if_ack", bus.if_ack, {31'b0, ~exp_dm});
         chk("cont_stall", bus.stall, 1);
         chk("cont_dm_rdata", bus.dm_rdata, 16'h5555);
         chk("cont_if_rdata", bus.if_rdata, (k == 0) ? 32'hCAFE : 32'h0F0F);
         step();
      end

      // reset during ACCESS
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      bus.if_req = 1'b1; bus.if_addr = 8'h10;
      step();
      chk("mid_c1_cs", bus.mem_cs, 1);
      step();
      rst = 1'b0;
      settle();
      chk("mid_rst_cs", bus.mem_cs, 0);
      chk("mid_rst_ack", bus.if_ack, 0);
      chk("mid_rst_stall", bus.stall, 1);
      chk("mid_rst_rdata", bus.if_rdata, 0);
      step();
      chk("mid_hold_cs", bus.mem_cs, 0);
      chk("mid_hold_ack", bus.if_ack, 0);
      rst = 1'b1;
      settle();
      chk("mid_rel_cs", bus.mem_cs, 0);
      step();
      chk("mid_r1_cs", bus.mem_cs, 1);
      chk("mid_r1_addr", bus.mem_addr, 8'h10);
      step();
      chk("mid_r2_ack", bus.if_ack, 0);
      step();
      chk("mid_r3_ack", bus.if_ack, 1);
      chk("mid_r3_rdata", bus.if_rdata, 16'h1234);
      bus.if_req = 1'b0;
      step();
      chk("mid_r4_ack", bus.if_ack, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
